// File: rtl/morse_tx_arbiter_pkg.sv
// Shared types and constants for the morse transmit arbiter and its round-robin picker.
package morse_pkg;

  localparam int ASCII_W = 8;
  localparam logic [ASCII_W-1:0] ASCII_SPACE = 8'h20;

  // ST_SEP is only reachable when MORSE_ARB_WORD_SEP_EN is defined.
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_SEP  = 2'd2
  } arb_state_t;

endpackage

// File: rtl/morse_tx_arbiter_if.sv
// Requester/encoder bundle for morse_tx_arbiter; slave = arbiter, master = requesters + encoder.
interface morse_tx_arbiter_if
  import morse_pkg::*;
#(
  parameter int N_REQ = 4
);
  logic [N_REQ-1:0]              req_valid;
  logic [N_REQ-1:0][ASCII_W-1:0] req_data;
  logic [N_REQ-1:0]              req_last;
  logic [N_REQ-1:0]              req_ready;
  logic                          enc_write_en;
  logic [ASCII_W-1:0]            enc_ascii;
  logic                          enc_full;
  logic [N_REQ-1:0]              grant;
  logic                          busy;
  logic                          timeout_pulse;

  modport master (
    output req_valid, req_data, req_last, enc_full,
    input  req_ready, enc_write_en, enc_ascii, grant, busy, timeout_pulse
  );

  modport slave (
    input  req_valid, req_data, req_last, enc_full,
    output req_ready, enc_write_en, enc_ascii, grant, busy, timeout_pulse
  );
endinterface

// File: rtl/morse_tx_arbiter_rr_pick.sv
// Combinational round-robin picker: first set request at or after ptr, wrapping modulo N.
module rr_pick #(
  parameter  int N  = 4,
  localparam int PW = $clog2(N),
  localparam int KW = PW + 1
) (
  input  logic [N-1:0]  req,
  input  logic [PW-1:0] ptr,
  output logic [N-1:0]  onehot,
  output logic [PW-1:0] idx,
  output logic          hit
);
  // Doubling the vector turns the wrap-around scan into a straight one.
  logic [2*N-1:0] req2;
  logic [KW-1:0]  k;

  assign req2 = {req, req};

  always_comb begin
    onehot = '0;
    idx    = '0;
    hit    = 1'b0;
    k      = '0;
    for (int i = 0; i < N; i++) begin
      k = {1'b0, ptr} + KW'(i);
      if (!hit && req2[k]) begin
        hit = 1'b1;
        idx = (k >= KW'(N)) ? PW'(k - KW'(N)) : PW'(k);
      end
    end
    if (hit) onehot[idx] = 1'b1;
  end
endmodule

// File: rtl/morse_tx_arbiter.sv
// Message-granular round-robin arbiter sharing one ascii2morse encoder write port.
// Optional MORSE_ARB_WORD_SEP_EN appends a space byte after every completed message.
module morse_tx_arbiter
  import morse_pkg::*;
#(
  parameter  int N_REQ   = 4,
  parameter  int TIMEOUT = 1024,
  localparam int TO_W    = $clog2(TIMEOUT + 1),
  localparam int PW      = $clog2(N_REQ)
) (
  input logic               clk,
  input logic               arst,
  morse_tx_arbiter_if.slave bus
);

  if (N_REQ < 2 || N_REQ > 8) begin : g_bad_nreq
    $error("morse_tx_arbiter: N_REQ must be 2..8");
  end
  if (TIMEOUT < 1) begin : g_bad_timeout
    $error("morse_tx_arbiter: TIMEOUT must be >= 1");
  end

  arb_state_t       state;
  logic [N_REQ-1:0] grant;
  logic [PW-1:0]    own;
  logic [PW-1:0]    rr_ptr;
  logic [TO_W-1:0]  idle_cnt;
  logic             timeout_pulse;

  logic [N_REQ-1:0] pick_oh;
  logic [PW-1:0]    pick_idx;
  logic             pick_hit;

  rr_pick #(.N(N_REQ)) u_rr_pick (
    .req    (bus.req_valid),
    .ptr    (rr_ptr),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .hit    (pick_hit)
  );

  logic own_valid;
  logic own_last;
  logic xfer_fire;

  assign own_valid = bus.req_valid[own];
  assign own_last  = bus.req_last[own];
  assign xfer_fire = (state == ST_XFER) && own_valid && !bus.enc_full;

  // Encoder side is a pure mux of the owner's inputs: no added latency once granted.
  logic [N_REQ-1:0]   req_ready;
  logic               enc_write_en;
  logic [ASCII_W-1:0] enc_ascii;

  always_comb begin
    req_ready    = '0;
    enc_write_en = 1'b0;
    enc_ascii    = '0;
    case (state)
      ST_XFER: begin
        enc_ascii      = bus.req_data[own];
        enc_write_en   = own_valid && !bus.enc_full;
        req_ready[own] = !bus.enc_full;
      end
`ifdef MORSE_ARB_WORD_SEP_EN
      ST_SEP: begin
        enc_ascii    = ASCII_SPACE;
        enc_write_en = !bus.enc_full;
      end
`endif
      default: ;
    endcase
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state         <= ST_IDLE;
      grant         <= '0;
      own           <= '0;
      rr_ptr        <= '0;
      idle_cnt      <= '0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      case (state)
        ST_IDLE: begin
          idle_cnt <= '0;
          if (pick_hit) begin
            grant  <= pick_oh;
            own    <= pick_idx;
            rr_ptr <= (pick_idx == PW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
            state  <= ST_XFER;
          end
        end
        ST_XFER: begin
          // An encoder stall with valid held counts as activity, never as idle.
          if (own_valid) begin
            idle_cnt <= '0;
            if (xfer_fire && own_last) begin
`ifdef MORSE_ARB_WORD_SEP_EN
              state <= ST_SEP;
`else
              state <= ST_IDLE;
              grant <= '0;
`endif
            end
          end else if (idle_cnt == TO_W'(TIMEOUT - 1)) begin
            idle_cnt      <= '0;
            timeout_pulse <= 1'b1;
            grant         <= '0;
            state         <= ST_IDLE;
          end else begin
            idle_cnt <= idle_cnt + 1'b1;
          end
        end
`ifdef MORSE_ARB_WORD_SEP_EN
        ST_SEP: begin
          if (!bus.enc_full) begin
            grant <= '0;
            state <= ST_IDLE;
          end
        end
`endif
        default: begin
          grant <= '0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.req_ready     = req_ready;
  assign bus.enc_write_en  = enc_write_en;
  assign bus.enc_ascii     = enc_ascii;
  assign bus.grant         = grant;
  assign bus.busy          = (state != ST_IDLE);
  assign bus.timeout_pulse = timeout_pulse;

endmodule

// File: tb/tb_morse_tx_arbiter.sv
// Directed bench for morse_tx_arbiter (N_REQ=4, TIMEOUT=8); follows MORSE_ARB_WORD_SEP_EN if defined.
module tb_morse_tx_arbiter;
  import morse_pkg::*;

  localparam int NR = 4;
  localparam int TO = 8;

  logic clk  = 1'b0;
  logic arst = 1'b1;

  morse_tx_arbiter_if #(.N_REQ(NR)) bus ();

  morse_tx_arbiter #(.N_REQ(NR), .TIMEOUT(TO)) dut (
    .clk  (clk),
    .arst (arst),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;
  int full_viol = 0;

  logic [7:0] src_q  [NR][$];
  bit         src_lq [NR][$];
  logic [7:0] wr_log [$];
  int         wr_cyc [$];
  logic [7:0] exp_q  [$];

  logic [NR-1:0] s_grant, s_ready;
  logic          s_we, s_busy, s_pulse;
  logic [7:0]    s_ascii;

  function automatic string q2s(logic [7:0] q[$]);
    string s = "";
    foreach (q[i]) s = {s, $sformatf("%02h ", q[i])};
    return s;
  endfunction

  task automatic load(int l, logic [7:0] b, bit last);
    src_q[l].push_back(b);
    src_lq[l].push_back(last);
  endtask

  // Expected encoder stream; a space follows each message when separators are built in.
  task automatic exp_push(logic [7:0] b, bit last);
    exp_q.push_back(b);
`ifdef MORSE_ARB_WORD_SEP_EN
    if (last) exp_q.push_back(8'h20);
`endif
  endtask

  task automatic drive_src();
    for (int l = 0; l < NR; l++) begin
      if (src_q[l].size() > 0) begin
        bus.req_valid[l] = 1'b1;
        bus.req_data[l]  = src_q[l][0];
        bus.req_last[l]  = src_lq[l][0];
      end else begin
        bus.req_valid[l] = 1'b0;
        bus.req_data[l]  = 8'h00;
        bus.req_last[l]  = 1'b0;
      end
    end
  endtask

  // One clock: sample at negedge, then advance requester queues on accepted bytes.
  task automatic step();
    logic [NR-1:0] hs;
    @(negedge clk);
    cyc++;
    s_grant = bus.grant;
    s_ready = bus.req_ready;
    s_we    = bus.enc_write_en;
    s_busy  = bus.busy;
    s_pulse = bus.timeout_pulse;
    s_ascii = bus.enc_ascii;
    hs = bus.req_valid & bus.req_ready;
    if (bus.enc_write_en && bus.enc_full) full_viol++;
    if (bus.enc_write_en && !bus.enc_full) begin
      wr_log.push_back(bus.enc_ascii);
      wr_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    for (int l = 0; l < NR; l++)
      if (hs[l]) begin
        void'(src_q[l].pop_front());
        void'(src_lq[l].pop_front());
      end
    drive_src();
  endtask

  task automatic do_reset();
    arst = 1'b1;
    bus.enc_full = 1'b0;
    for (int l = 0; l < NR; l++) begin
      src_q[l].delete();
      src_lq[l].delete();
    end
    drive_src();
    wr_log.delete();
    wr_cyc.delete();
    exp_q.delete();
    full_viol = 0;
    repeat (2) @(posedge clk);
    #1 arst = 1'b0;
  endtask

  task automatic test_reset();
    arst = 1'b1;
    bus.enc_full  = 1'b0;
    bus.req_valid = '1;
    bus.req_data  = {NR{8'h41}};
    bus.req_last  = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0) begin
      fails++;
      $display("FAIL reset_grant_busy: grant=%b busy=%b, expected 0000/0", bus.grant, bus.busy);
    end
    tests++;
    if (bus.enc_write_en !== 1'b0 || bus.enc_ascii !== 8'h00) begin
      fails++;
      $display("FAIL reset_enc: we=%b ascii=%02h, expected 0/00", bus.enc_write_en, bus.enc_ascii);
    end
    tests++;
    if (bus.req_ready !== '0 || bus.timeout_pulse !== 1'b0) begin
      fails++;
      $display("FAIL reset_ready_pulse: ready=%b pulse=%b, expected 0000/0", bus.req_ready, bus.timeout_pulse);
    end
  endtask

  task automatic test_sos();
    do_reset();
    load(0, 8'h53, 0); load(0, 8'h4F, 0); load(0, 8'h53, 1);
    exp_push(8'h53, 0); exp_push(8'h4F, 0); exp_push(8'h53, 1);
    drive_src();
    step();
    tests++;
    if (s_grant !== 4'b0000 || s_we !== 1'b0) begin
      fails++;
      $display("FAIL sos_arb_cycle: grant=%b we=%b, expected 0000/0", s_grant, s_we);
    end
    step();
    tests++;
    if (s_grant !== 4'b0001 || s_we !== 1'b1 || s_ascii !== 8'h53 || s_busy !== 1'b1) begin
      fails++;
      $display("FAIL sos_first: grant=%b we=%b ascii=%02h busy=%b, expected 0001/1/53/1",
               s_grant, s_we, s_ascii, s_busy);
    end
    repeat (6) step();
    tests++;
    if (q2s(wr_log) != q2s(exp_q)) begin
      fails++;
      $display("FAIL sos_stream: got %s expected %s", q2s(wr_log), q2s(exp_q));
    end
    tests++;
    if (wr_cyc.size() < 3 || wr_cyc[2] - wr_cyc[0] != 2) begin
      fails++;
      $display("FAIL sos_consecutive: %0d writes, expected 3 on consecutive cycles", wr_cyc.size());
    end
    tests++;
    if (s_grant !== 4'b0000 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL sos_idle: grant=%b busy=%b, expected 0000/0", s_grant, s_busy);
    end
  endtask

  task automatic test_round_robin();
    do_reset();
    for (int l = 0; l < NR; l++) begin
      load(l, 8'(8'h10 * l), 0);
      load(l, 8'(8'h10 * l + 1), 1);
    end
    load(0, 8'h02, 0); load(0, 8'h03, 1);
    for (int l = 0; l < NR; l++) begin
      exp_push(8'(8'h10 * l), 0);
      exp_push(8'(8'h10 * l + 1), 1);
    end
    exp_push(8'h02, 0); exp_push(8'h03, 1);
    drive_src();
    repeat (30) step();
    tests++;
    if (q2s(wr_log) != q2s(exp_q)) begin
      fails++;
      $display("FAIL rr_order: got %s expected %s", q2s(wr_log), q2s(exp_q));
    end
    tests++;
    if (s_grant !== 4'b0000 || s_busy !== 1'b0) begin
      fails++;
      $display("FAIL rr_drained: grant=%b busy=%b, expected 0000/0", s_grant, s_busy);
    end
  endtask

  task automatic test_full_stall();
    int bad = 0;
    do_reset();
    load(2, 8'h41, 0); load(2, 8'h42, 0); load(2, 8'h43, 1);
    exp_push(8'h41, 0); exp_push(8'h42, 0); exp_push(8'h43, 1);
    drive_src();
    step();
    step();
    bus.enc_full = 1'b1;
    repeat (50) begin
      step();
      if (s_we !== 1'b0 || s_ready !== '0 || s_pulse !== 1'b0) bad++;
    end
    tests++;
    if (bad != 0) begin
      fails++;
      $display("FAIL stall_quiet: %0d cycles with we/ready/pulse set, expected 0", bad);
    end
    tests++;
    if (s_grant !== 4'b0100) begin
      fails++;
      $display("FAIL stall_grant_held: grant=%b, expected 0100", s_grant);
    end
    bus.enc_full = 1'b0;
    step();
    tests++;
    if (s_we !== 1'b1 || s_ascii !== 8'h42) begin
      fails++;
      $display("FAIL stall_resume: we=%b ascii=%02h, expected 1/42", s_we, s_ascii);
    end
    repeat (4) step();
    tests++;
    if (q2s(wr_log) != q2s(exp_q) || full_viol != 0) begin
      fails++;
      $display("FAIL stall_stream: got %s (%0d writes while full) expected %s",
               q2s(wr_log), full_viol, q2s(exp_q));
    end
  endtask

  task automatic test_timeout();
    int x_cyc;
    int p_cyc = -1;
    int npulse = 0;
    do_reset();
    load(1, 8'h58, 0);
    load(3, 8'h59, 1);
    exp_push(8'h58, 0); exp_push(8'h59, 1);
    drive_src();
    step();
    step();
    x_cyc = cyc;
    for (int i = 0; i < 30 && p_cyc < 0; i++) begin
      step();
      if (s_pulse === 1'b1) begin
        p_cyc = cyc;
        npulse++;
        tests++;
        if (s_grant !== 4'b0000) begin
          fails++;
          $display("FAIL timeout_grant_drop: grant=%b, expected 0000", s_grant);
        end
      end
    end
    tests++;
    if (p_cyc - x_cyc != TO + 1) begin
      fails++;
      $display("FAIL timeout_latency: pulse %0d cycles after last byte, expected %0d", p_cyc - x_cyc, TO + 1);
    end
    step();
    tests++;
    if (s_pulse !== 1'b0 || s_grant !== 4'b1000 || s_we !== 1'b1 || s_ascii !== 8'h59) begin
      fails++;
      $display("FAIL timeout_regrant: pulse=%b grant=%b we=%b ascii=%02h, expected 0/1000/1/59",
               s_pulse, s_grant, s_we, s_ascii);
    end
    repeat (4) step();
    tests++;
    if (q2s(wr_log) != q2s(exp_q) || npulse != 1) begin
      fails++;
      $display("FAIL timeout_stream: got %s pulses=%0d expected %s pulses=1", q2s(wr_log), npulse, q2s(exp_q));
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    load(2, 8'h50, 0); load(2, 8'h51, 0); load(2, 8'h52, 0); load(2, 8'h53, 1);
    drive_src();
    step();
    step();
    step();
    load(0, 8'h5A, 1);
    drive_src();
    #2 arst = 1'b1;
    #1;
    tests++;
    if (bus.grant !== '0 || bus.busy !== 1'b0 || bus.enc_write_en !== 1'b0) begin
      fails++;
      $display("FAIL rst_mid_drop: grant=%b busy=%b we=%b, expected 0000/0/0",
               bus.grant, bus.busy, bus.enc_write_en);
    end
    @(posedge clk);
    #1 arst = 1'b0;
    step();
    step();
    tests++;
    if (s_grant !== 4'b0001 || s_we !== 1'b1 || s_ascii !== 8'h5A) begin
      fails++;
      $display("FAIL rst_mid_rr_ptr0: grant=%b we=%b ascii=%02h, expected 0001/1/5a", s_grant, s_we, s_ascii);
    end
  endtask

  task automatic test_release_rr();
    do_reset();
    load(1, 8'h61, 1); load(1, 8'h62, 1);
    load(3, 8'h63, 1);
    exp_push(8'h61, 1); exp_push(8'h63, 1); exp_push(8'h62, 1);
    drive_src();
    repeat (15) step();
    tests++;
    if (q2s(wr_log) != q2s(exp_q)) begin
      fails++;
      $display("FAIL release_rr: got %s expected %s", q2s(wr_log), q2s(exp_q));
    end
  endtask

  initial begin
    bus.enc_full  = 1'b0;
    bus.req_valid = '0;
    bus.req_data  = '0;
    bus.req_last  = '0;
    test_reset();
    test_sos();
    test_round_robin();
    test_full_stall();
    test_timeout();
    test_reset_mid();
    test_release_rr();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
